// File: rtl/calc_pkg.sv
// Shared definitions for the calc arbiter slice:
// FSM encoding, operand width and result selects.
package calc_pkg;

   localparam int W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] SEL_C = 3'd0;
   localparam logic [2:0] SEL_D = 3'd1;
   localparam logic [2:0] SEL_E = 3'd2;
   localparam logic [2:0] SEL_F = 3'd3;
   localparam logic [2:0] SEL_G = 3'd4;
   localparam logic [2:0] SEL_H = 3'd5;
   localparam logic [2:0] SEL_I = 3'd6;
   localparam logic [2:0] SEL_J = 3'd7;

endpackage

// File: rtl/num_calculation.sv
// Combinational 3-bit calculator: eight results
// from two operands, all truncated to 3 bits.
module num_calculation
   import calc_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] c,
   output logic [W-1:0] d,
   output logic [W-1:0] e,
   output logic [W-1:0] f,
   output logic [W-1:0] g,
   output logic [W-1:0] h,
   output logic [W-1:0] i,
   output logic [W-1:0] j
);

   assign c = a + b;
   assign d = a - b;
   assign e = a & b;
   assign f = a | b;
   assign g = a ^ b;
   assign h = a * b;
   assign i = ~a;
   assign j = (a > b) ? a : b;

endmodule

// File: rtl/calc_arbiter.sv
// Two requesters share one num_calculation,
// one operation in flight, RR or fixed priority.
module calc_arbiter
   import calc_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [2:0]   req0_sel,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req1_sel,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         busy
);

   state_t       state_q;
   state_t       state_d;
   logic         last_q;
   logic         gnt1;
   logic         idle;
   logic         accept;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [2:0]   sel_q;
   logic         id_q;
   logic [W-1:0] res;
   logic [W-1:0] c, d, e, f, g, h, i, j;

   // Grant select: contention resolved by priority mode
   always_comb begin
      gnt1 = req1_valid;
      if (req0_valid && req1_valid) begin
         gnt1 = FIXED_PRIO ? 1'b0 : ~last_q;
      end
      idle       = (state_q == IDLE) && rst_n;
      req0_ready = idle && req0_valid && !gnt1;
      req1_ready = idle && req1_valid && gnt1;
      accept     = req0_ready || req1_ready;
   end

   // Next-state logic for the IDLE/EXEC/RESP cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Capture operands and grant on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sel_q  <= '0;
         id_q   <= 1'b0;
         last_q <= 1'b1;
      end else if (accept) begin
         a_q    <= gnt1 ? req1_a : req0_a;
         b_q    <= gnt1 ? req1_b : req0_b;
         sel_q  <= gnt1 ? req1_sel : req0_sel;
         id_q   <= gnt1;
         last_q <= gnt1;
      end
   end

   num_calculation u_calc (
      .a(a_q), .b(b_q),
      .c(c), .d(d), .e(e), .f(f),
      .g(g), .h(h), .i(i), .j(j)
   );

   // Pick the requested result
   always_comb begin
      res = c;
      unique case (sel_q)
         SEL_C: res = c;
         SEL_D: res = d;
         SEL_E: res = e;
         SEL_F: res = f;
         SEL_G: res = g;
         SEL_H: res = h;
         SEL_I: res = i;
         SEL_J: res = j;
         default: res = c;
      endcase
   end

   // Response registers: loaded in EXEC, held through RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
      end else if (state_q == EXEC) begin
         rsp_valid <= 1'b1;
         rsp_id    <= id_q;
         rsp_data  <= res;
      end else if (state_q == RESP && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: vector table, corner
// sequences and a random run against a model.
module tb_calc_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic [2:0] a0 = '0, b0 = '0, s0 = '0;
   logic [2:0] a1 = '0, b1 = '0, s1 = '0;
   logic       rsp_ready = 1'b0;

   logic       r0, r1, rv, rid, bsy;
   logic [2:0] rdat;
   logic       f_r0, f_r1, f_rv, f_rid, f_bsy;
   logic [2:0] f_rdat;

   int nchecks = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   calc_arbiter #(.FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0),
      .req0_a(a0), .req0_b(b0), .req0_sel(s0),
      .req1_valid(v1), .req1_ready(r1),
      .req1_a(a1), .req1_b(b1), .req1_sel(s1),
      .rsp_valid(rv), .rsp_ready(rsp_ready),
      .rsp_id(rid), .rsp_data(rdat), .busy(bsy)
   );

   calc_arbiter #(.FIXED_PRIO(1'b1)) dut_fix (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(f_r0),
      .req0_a(a0), .req0_b(b0), .req0_sel(s0),
      .req1_valid(v1), .req1_ready(f_r1),
      .req1_a(a1), .req1_b(b1), .req1_sel(s1),
      .rsp_valid(f_rv), .rsp_ready(rsp_ready),
      .rsp_id(f_rid), .rsp_data(f_rdat), .busy(f_bsy)
   );

   typedef struct {
      logic       rq;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] sel;
      logic [2:0] exp;
   } vec_t;

   vec_t vt[8];

   function automatic logic [2:0] ref_calc(int a, int b, int sel);
      int r;
      case (sel)
         0: r = (a + b) % 8;
         1: r = (a - b + 8) % 8;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (a * b) % 8;
         6: r = 7 - a;
         default: r = (a > b) ? a : b;
      endcase
      return 3'(r);
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      rsp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic do_op(input logic rq, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] sel,
                        input bit hold, output logic [2:0] data,
                        output logic id);
      int n = 0;
      rsp_ready = 1'b0;
      if (rq) begin
         v1 = 1'b1; a1 = a; b1 = b; s1 = sel;
      end else begin
         v0 = 1'b1; a0 = a; b0 = b; s0 = sel;
      end
      #1;
      while (!(rq ? r1 : r0) && n < 10) begin
         step();
         n++;
      end
      chk("op_ready_timeout", 8'(n < 10), 8'd1);
      step();
      v0 = 1'b0;
      v1 = 1'b0;
      chk("exec_no_rsp", 8'(rv), 8'd0);
      chk("exec_busy", 8'(bsy), 8'd1);
      step();
      chk("resp_valid", 8'(rv), 8'd1);
      data = rdat;
      id = rid;
      if (!hold) begin
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
   endtask

   logic [2:0] dat, hd;
   logic       id, hid;
   int         exp_alt, nrsp, nfix;

   // random-run model state
   int         m_wait;
   bit         m_rv, m_id, m_last, p_id;
   logic [2:0] m_data, p_data;
   bit         h0, h1, e0, e1, g0, free;

   initial begin
      vt[0] = '{1'b0, 3'd5, 3'd3, 3'd0, 3'd0};
      vt[1] = '{1'b1, 3'd5, 3'd3, 3'd1, 3'd2};
      vt[2] = '{1'b0, 3'd6, 3'd3, 3'd2, 3'd2};
      vt[3] = '{1'b1, 3'd4, 3'd1, 3'd3, 3'd5};
      vt[4] = '{1'b0, 3'd7, 3'd2, 3'd4, 3'd5};
      vt[5] = '{1'b1, 3'd3, 3'd3, 3'd5, 3'd1};
      vt[6] = '{1'b0, 3'd2, 3'd0, 3'd6, 3'd5};
      vt[7] = '{1'b1, 3'd2, 3'd6, 3'd7, 3'd6};

      // reset values, readies gated while in reset
      do_reset();
      rst_n = 1'b0;
      v0 = 1'b1;
      v1 = 1'b1;
      #1;
      chk("rst_r0", 8'(r0), 8'd0);
      chk("rst_r1", 8'(r1), 8'd0);
      chk("rst_rv", 8'(rv), 8'd0);
      chk("rst_busy", 8'(bsy), 8'd0);
      chk("rst_id", 8'(rid), 8'd0);
      chk("rst_data", 8'(rdat), 8'd0);
      v0 = 1'b0;
      v1 = 1'b0;
      do_reset();

      // first operation latency
      v0 = 1'b1; a0 = 3'd5; b0 = 3'd3; s0 = 3'd0;
      #1;
      chk("first_r0", 8'(r0), 8'd1);
      chk("first_r1", 8'(r1), 8'd0);
      chk("first_idle", 8'(bsy), 8'd0);
      step();
      v0 = 1'b0;
      chk("first_edge1_rv", 8'(rv), 8'd0);
      chk("first_edge1_busy", 8'(bsy), 8'd1);
      step();
      chk("first_edge2_rv", 8'(rv), 8'd1);
      chk("first_id", 8'(rid), 8'd0);
      chk("first_data", 8'(rdat), 8'(ref_calc(5, 3, 0)));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("first_done", 8'(rv), 8'd0);

      // table vectors
      for (int k = 0; k < 8; k++) begin
         do_op(vt[k].rq, vt[k].a, vt[k].b, vt[k].sel, 1'b0, dat, id);
         chk("vec_data", 8'(dat), 8'(vt[k].exp));
         chk("vec_id", 8'(id), 8'(vt[k].rq));
      end

      // sel sweep with random operands
      for (int k = 0; k < 8; k++) begin
         logic [2:0] ra, rb;
         ra = 3'($urandom);
         rb = 3'($urandom);
         do_op(1'b0, ra, rb, 3'(k), 1'b0, dat, id);
         chk("sweep_data", 8'(dat), 8'(ref_calc(ra, rb, k)));
      end

      // response held while consumer stalls
      do_op(1'b0, 3'd6, 3'd5, 3'd4, 1'b1, hd, hid);
      v0 = 1'b1;
      v1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hold_rv", 8'(rv), 8'd1);
         chk("hold_data", 8'(rdat), 8'(hd));
         chk("hold_id", 8'(rid), 8'(hid));
         chk("hold_r0", 8'(r0), 8'd0);
         chk("hold_r1", 8'(r1), 8'd0);
         chk("hold_busy", 8'(bsy), 8'd1);
      end
      chk("hold_value", 8'(hd), 8'd3);
      v0 = 1'b0;
      v1 = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("hold_release", 8'(rv), 8'd0);

      // reset during EXEC discards the operation
      do_reset();
      do_op(1'b0, 3'd1, 3'd1, 3'd0, 1'b0, dat, id);
      v1 = 1'b1; a1 = 3'd2; b1 = 3'd2; s1 = 3'd0;
      #1;
      chk("midrst_r1", 8'(r1), 8'd1);
      step();
      v1 = 1'b0;
      chk("midrst_exec", 8'(bsy), 8'd1);
      #1;
      rst_n = 1'b0;
      v0 = 1'b1;
      v1 = 1'b1;
      #1;
      chk("midrst_busy", 8'(bsy), 8'd0);
      chk("midrst_rv", 8'(rv), 8'd0);
      chk("midrst_r0", 8'(r0), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_next_r0", 8'(r0), 8'd1);
      chk("midrst_next_r1", 8'(r1), 8'd0);
      v0 = 1'b0;
      v1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("midrst_no_rsp", 8'(rv), 8'd0);
      end

      // contention: RR alternates, fixed prio always 0
      do_reset();
      v0 = 1'b1; a0 = 3'd1; b0 = 3'd2; s0 = 3'd0;
      v1 = 1'b1; a1 = 3'd3; b1 = 3'd4; s1 = 3'd0;
      rsp_ready = 1'b1;
      exp_alt = 0;
      nrsp = 0;
      nfix = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         chk("fix_r1", 8'(f_r1), 8'd0);
         if (rv) begin
            chk("rr_id", 8'(rid), 8'(exp_alt));
            exp_alt ^= 1;
            nrsp++;
         end
         if (f_rv) begin
            chk("fix_id", 8'(f_rid), 8'd0);
            nfix++;
         end
      end
      chk("rr_count", 8'(nrsp), 8'd8);
      chk("fix_count", 8'(nfix), 8'd8);
      @(posedge clk);
      #1;

      // randomized run against the model
      do_reset();
      m_wait = -1;
      m_rv = 0;
      m_last = 1;
      m_id = 0;
      m_data = '0;
      h0 = 0;
      h1 = 0;
      for (int k = 0; k < 400; k++) begin
         if (!h0) begin
            v0 = 1'($urandom);
            a0 = 3'($urandom); b0 = 3'($urandom); s0 = 3'($urandom);
         end
         if (!h1) begin
            v1 = 1'($urandom);
            a1 = 3'($urandom); b1 = 3'($urandom); s1 = 3'($urandom);
         end
         rsp_ready = 1'($urandom);
         @(negedge clk);
         free = (m_wait < 0) && !m_rv;
         g0 = v0 && (!v1 || m_last);
         e0 = free && g0;
         e1 = free && v1 && !g0;
         chk("rnd_r0", 8'(r0), 8'(e0));
         chk("rnd_r1", 8'(r1), 8'(e1));
         chk("rnd_rv", 8'(rv), 8'(m_rv));
         chk("rnd_busy", 8'(bsy), 8'(!free));
         if (m_rv) begin
            chk("rnd_id", 8'(rid), 8'(m_id));
            chk("rnd_data", 8'(rdat), 8'(m_data));
         end
         if (m_rv && rsp_ready) m_rv = 0;
         if (m_wait == 1) begin
            m_rv = 1;
            m_id = p_id;
            m_data = p_data;
            m_wait = -1;
         end
         if (e0 || e1) begin
            m_wait = 1;
            p_id = e1;
            p_data = e1 ? ref_calc(a1, b1, s1) : ref_calc(a0, b0, s0);
            m_last = e1;
         end
         h0 = v0 && !e0;
         h1 = v1 && !e1;
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
      $finish;
   end

endmodule
